// File: rtl/countdown_core_pkg.sv
// Shared types and constants for the MM:SS countdown: FSM states and the
// four-digit BCD time value.
package countdown_core_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] SEC_TENS_WRAP = 4'd5;
  localparam logic [DIGIT_W-1:0] ONES_WRAP     = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_EXPIRED
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } bcd_time_t;

endpackage

// File: rtl/countdown_core_tick_sync.sv
// Brings the slow tick_in square wave into the clk_in domain and flags its
// rising edge for one cycle.
module tick_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // NOTE: non-blocking assignments make every stage take its neighbour's old
  // value, so the chain shifts by exactly one flop per clock.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/countdown_core.sv
// MM:SS BCD countdown driven by the synchronized one-second tick, with
// load/start/pause control and a registered expiry indication.
module countdown_core
  import countdown_core_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_VAL     = 59
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       load,
  input  logic [6:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam logic [6:0] MAX_MIN = 7'(MAX_VAL);
  localparam logic [5:0] MAX_SEC = 6'(MAX_VAL);

  state_e    state_q, state_d;
  bcd_time_t cnt_q, cnt_d, cnt_dec;
  logic      running_q, running_d;
  logic      expired_q, expired_d;
  logic      done_q, done_d;
  logic      tick_rise;
  logic [6:0] min_clamp;
  logic [5:0] sec_clamp;

  tick_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
    .clk_in   (clk_in),
    .rst      (rst),
    .async_in (tick_in),
    .rise     (tick_rise)
  );

  // Only valid for 0..59, which the clamp guarantees.
  function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  assign min_clamp = (load_min > MAX_MIN) ? MAX_MIN : load_min;
  assign sec_clamp = (load_sec > MAX_SEC) ? MAX_SEC : load_sec;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/else chain can leave it unassigned and infer a latch.
  always_comb begin
    cnt_dec = cnt_q;
    if (cnt_q.sec_ones != '0) begin
      cnt_dec.sec_ones = cnt_q.sec_ones - 4'd1;
    end else begin
      cnt_dec.sec_ones = ONES_WRAP;
      if (cnt_q.sec_tens != '0) begin
        cnt_dec.sec_tens = cnt_q.sec_tens - 4'd1;
      end else begin
        cnt_dec.sec_tens = SEC_TENS_WRAP;
        if (cnt_q.min_ones != '0) begin
          cnt_dec.min_ones = cnt_q.min_ones - 4'd1;
        end else begin
          cnt_dec.min_ones = ONES_WRAP;
          cnt_dec.min_tens = cnt_q.min_tens - 4'd1;
        end
      end
    end
  end

  // Commands are resolved in priority order; a command that does not apply in
  // the current state does not block a tick behind it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (load) begin
      cnt_d   = {bin_to_bcd(min_clamp), bin_to_bcd({1'b0, sec_clamp})};
      state_d = ST_IDLE;
    end else if (pause && state_q == ST_RUN) begin
      state_d = ST_PAUSE;
    end else if (start && (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
      if (cnt_q != '0) state_d = ST_RUN;
    end else if (tick_rise && state_q == ST_RUN) begin
      if (cnt_q == 16'h0001) begin
        cnt_d   = '0;
        state_d = ST_EXPIRED;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_dec;
      end
    end
    running_d = (state_d == ST_RUN);
    expired_d = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      expired_q <= expired_d;
      done_q    <= done_d;
    end
  end

  assign min_tens = cnt_q.min_tens;
  assign min_ones = cnt_q.min_ones;
  assign sec_tens = cnt_q.sec_tens;
  assign sec_ones = cnt_q.sec_ones;
  assign running  = running_q;
  assign expired  = expired_q;
  assign done     = done_q;

endmodule

// File: tb/tb_countdown_core.sv
// Scoreboard bench for countdown_core: a seconds-count reference model
// predicts every output change and the cycle it lands on.
module tb_countdown_core;

  localparam int S = 2;

  logic       clk_in = 1'b0;
  logic       rst, tick_in, load, start, pause;
  logic [6:0] load_min;
  logic [5:0] load_sec;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, expired, done;

  countdown_core #(.SYNC_STAGES(S), .MAX_VAL(59)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .tick_in  (tick_in),
    .load     (load),
    .load_min (load_min),
    .load_sec (load_sec),
    .start    (start),
    .pause    (pause),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .running  (running),
    .expired  (expired),
    .done     (done)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0] min_t, min_o, sec_t, sec_o;
    logic       run, exp, dn;
  } snap_t;

  typedef struct {
    int    cyc;
    snap_t s;
  } exp_t;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} mstate_t;

  exp_t    sb_q[$];
  int      n_cmp  = 0;
  int      n_fail = 0;
  bit      mon_en = 0;
  snap_t   mon_last;

  int      m_total = 0;
  mstate_t m_state = M_IDLE;
  bit      m_done  = 0;
  bit      tick_lvl = 0;
  bit      tick_at [0:16383];
  snap_t   last_exp;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic snap_t dut_snap();
    snap_t s;
    s.min_t = min_tens;
    s.min_o = min_ones;
    s.sec_t = sec_tens;
    s.sec_o = sec_ones;
    s.run   = running;
    s.exp   = expired;
    s.dn    = done;
    return s;
  endfunction

  function automatic snap_t model_out();
    snap_t s;
    int mins, secs;
    mins    = m_total / 60;
    secs    = m_total % 60;
    s.min_t = 4'(mins / 10);
    s.min_o = 4'(mins % 10);
    s.sec_t = 4'(secs / 10);
    s.sec_o = 4'(secs % 10);
    s.run   = (m_state == M_RUN);
    s.exp   = (m_state == M_EXP);
    s.dn    = m_done;
    return s;
  endfunction

  // Drives inputs for the next edge and predicts the state after it.
  task automatic drive(bit r, bit ld, int lm, int ls, bit st, bit pa);
    int    n;
    bit    rise;
    snap_t e;
    rst      = r;
    load     = ld;
    load_min = 7'(lm);
    load_sec = 6'(ls);
    start    = st;
    pause    = pa;
    tick_in  = tick_lvl;
    n = cyc + 1;
    tick_at[n] = r ? 1'b0 : tick_lvl;
    rise = (n > S) && tick_at[n-S] && !tick_at[n-S-1];
    m_done = 0;
    if (r) begin
      m_total = 0;
      m_state = M_IDLE;
    end else if (ld) begin
      m_total = (lm > 59 ? 59 : lm) * 60 + (ls > 59 ? 59 : ls);
      m_state = M_IDLE;
    end else if (pa && m_state == M_RUN) begin
      m_state = M_PAUSE;
    end else if (st && (m_state == M_IDLE || m_state == M_PAUSE)) begin
      if (m_total != 0) m_state = M_RUN;
    end else if (rise && m_state == M_RUN) begin
      m_total--;
      if (m_total == 0) begin
        m_state = M_EXP;
        m_done  = 1;
      end
    end
    e = model_out();
    if (e !== last_exp) begin
      sb_q.push_back('{n, e});
      last_exp = e;
    end
  endtask

  task automatic step(bit r, bit ld, int lm, int ls, bit st, bit pa);
    @(negedge clk_in);
    drive(r, ld, lm, ls, st, pa);
  endtask

  task automatic idle(int k);
    repeat (k) step(0, 0, 0, 0, 0, 0);
  endtask

  // One tick_in period (4 high, 4 low); the command lands on the edge where
  // the synchronized rise is seen.
  task automatic tick_cmd(bit ld, int lm, int ls, bit st, bit pa);
    tick_lvl = 1;
    idle(S);
    step(0, ld, lm, ls, st, pa);
    idle(1);
    tick_lvl = 0;
    idle(4);
  endtask

  // Monitor: every observed output change must match the next queued
  // prediction, on the predicted cycle.
  initial begin
    snap_t obs;
    exp_t  e;
    forever begin
      @(negedge clk_in);
      if (mon_en) begin
        obs = dut_snap();
        if (obs !== mon_last) begin
          mon_last = obs;
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_change: got %h expected no change (cycle %0d)", obs, cyc);
          end else begin
            e = sb_q.pop_front();
            check("outputs", 32'(obs), 32'(e.s));
            check("update_cycle", cyc, e.cyc);
          end
        end
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
          e = sb_q.pop_front();
          n_cmp++;
          n_fail++;
          $display("FAIL missed_update: got %h expected %h at cycle %0d", obs, e.s, e.cyc);
        end
      end
    end
  end

  initial begin
    int hold;
    rst = 1; load = 0; start = 0; pause = 0; tick_in = 0;
    load_min = '0; load_sec = '0;

    // Reset while tick_in toggles, then a start on 00:00 must be ignored.
    for (int i = 0; i < 4; i++) begin
      tick_lvl = ~tick_lvl;
      step(1, 0, 0, 0, 0, 0);
    end
    @(negedge clk_in);
    check("reset_state", 32'(dut_snap()), 32'(model_out()));
    sb_q.delete();
    last_exp = model_out();
    mon_last = dut_snap();
    mon_en   = 1;
    drive(0, 0, 0, 0, 1, 0);
    idle(6);

    // 01:05 down through 00:59.
    step(0, 1, 1, 5, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    repeat (6) tick_cmd(0, 0, 0, 0, 0);

    // Expiry, then EXPIRED holds until a load.
    step(0, 1, 0, 2, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    repeat (2) tick_cmd(0, 0, 0, 0, 0);
    repeat (2) tick_cmd(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(3);
    step(0, 1, 0, 10, 0, 0);
    idle(2);

    // Clamp to 59:59 and cross a minute boundary.
    step(0, 1, 99, 63, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    repeat (60) tick_cmd(0, 0, 0, 0, 0);

    // Pause and start, each coincident with a tick edge.
    tick_cmd(0, 0, 0, 0, 1);
    repeat (2) tick_cmd(0, 0, 0, 0, 0);
    tick_cmd(0, 0, 0, 1, 0);
    tick_cmd(0, 0, 0, 0, 0);

    // Load beats start and tick; reset mid-run.
    tick_cmd(1, 3, 30, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    repeat (2) tick_cmd(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(3);

    // Randomized traffic.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, ld, st, pa;
      int lm, ls;
      if (hold == 0) begin
        tick_lvl = ~tick_lvl;
        hold = int'($urandom_range(3, 8));
      end
      hold--;
      r  = ($urandom_range(0, 799) == 0);
      ld = ($urandom_range(0, 299) == 0);
      lm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 127)) : 0;
      ls = int'($urandom_range(0, 63));
      st = ($urandom_range(0, 11) == 0) && (m_state != M_RUN);
      pa = ($urandom_range(0, 59) == 0);
      step(r, ld, lm, ls, st, pa);
    end

    idle(6);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_core.md
# countdown_core

Consumer end of the one-second tick produced by the divided-clock generator. It synchronizes the slow `tick_in` square wave into the `clk_in` domain and detects its rising edges. On each rising edge it decrements an MM:SS countdown held as four BCD digits, under load/start/pause control. Its outputs drive the seven-segment display path and the expiry indicator.

## Interface
Parameters:
- `SYNC_STAGES`, 2, number of synchronizer flops on `tick_in` (minimum 2).
- `MAX_VAL`, 59, clamp limit for loaded minutes and seconds.

Ports:
- `clk_in`  in  1  system clock.
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `tick_in`  in  1  divided clock. Each rising edge marks one elapsed second. Asynchronous to `clk_in` in phase.
- `load`  in  1  single-cycle pulse that loads the countdown value.
- `load_min`  in  7  binary minutes for `load`.
- `load_sec`  in  6  binary seconds for `load`.
- `start`  in  1  single-cycle pulse that begins or resumes counting.
- `pause`  in  1  single-cycle pulse that suspends counting.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD count.
- `running`  out  1  high while in RUN.
- `expired`  out  1  level signal, high in EXPIRED.
- `done`  out  1  one-cycle pulse on reaching 00:00.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED.
- Reset values: state IDLE, all digits 0, `running`=0, `expired`=0, `done`=0, synchronizer and edge flops 0.
- Priority within one cycle: `rst` > `load` > `pause` > `start` > tick.
- `load` in any state:
  - Clamps each field to `MAX_VAL`, converts it to BCD and loads the digits.
  - Goes to IDLE, clears `expired`, and does not decrement that cycle.
- `start` in IDLE or PAUSE with a nonzero count goes to RUN.
- `start` with count 00:00 is ignored.
- `start` while in RUN or EXPIRED is ignored.
- `pause` in RUN goes to PAUSE. It is ignored in all other states.
- Tick edge in RUN decrements by one second:
  - `sec_ones` 0 borrows from `sec_tens`. `sec_tens` 0 wraps to 5 and borrows from minutes.
  - Minutes borrow in the same way, `min_ones` 0 → 9 with `min_tens` −1.
  - Example: 10:00 → 09:59.
- Tick edge at 00:01 in RUN:
  - Digits become 00:00, `done` pulses for exactly that cycle, state goes to EXPIRED.
- Tick edges outside RUN are discarded. They are not queued.
- A tick in the same cycle as `start` from IDLE/PAUSE does not decrement; the first decrement occurs on the next tick edge.
- A tick in the same cycle as `pause`: pause wins and there is no decrement.
- EXPIRED holds 00:00. Only `load` or `rst` leaves it.
- Edge detection:
  - `tick_rise = sync_last & ~prev`.
  - After reset, a `tick_in` that is already high yields one rise. This is harmless because the state is not RUN.

## Timing
- `tick_in` high first sampled at edge k → digits update at edge k+`SYNC_STAGES`. Latency is 2 cycles at the default.
- `done`, `expired` and the RUN→EXPIRED transition are registered on the same edge as the final decrement.
- `load`, `start` and `pause` take effect on the clock edge where they are sampled high. Outputs reflect the change the following cycle.
- `running` is registered and equals (state==RUN).
- No combinational path from any input to any output.
- Minimum `tick_in` high/low time is `SYNC_STAGES`+1 `clk_in` cycles. A shorter pulse may be missed.

## Structure
- Shared package holds:
  - The state enumeration (IDLE, RUN, PAUSE, EXPIRED).
  - BCD digit width (4).
  - Seconds-tens wrap value (5).
- Sub-module `tick_sync_edge`:
  - Parameter `SYNC_STAGES`; ports `clk_in`, `rst`, `async_in`, `rise`.
  - Contains the synchronizer chain plus the edge flop.
- Top level holds the FSM, load clamp, binary-to-BCD conversion (0–59 only) and the BCD borrow chain.

## Test plan
- Reset with `tick_in` toggling → digits 00:00, IDLE, `running`=0, no `done`. Then `start` → remains IDLE.
- `load` 1:05, `start`, 6 tick edges → 01:04, 01:03 … 00:59 in order. Each update lands exactly 2 cycles after the `tick_in` rise.
- `load` 0:02, `start`, 2 ticks → 00:00, one-cycle `done`, `expired`=1. Further ticks and `start` → no change. `load` 0:10 → IDLE, `expired`=0.
- `load_min`=99, `load_sec`=63 → 59:59. Run 60 ticks → 58:59.
- RUN, then `pause` coincident with a tick edge → no decrement, PAUSE, later ticks ignored. `start` with a coincident tick → RUN with no decrement; the next tick decrements.
- `load` coincident with `start` and a tick while in RUN → loaded value, IDLE. `rst` asserted mid-RUN → 00:00, IDLE next cycle.
